// File: rtl/calc_pkg.sv
// Package: calc_pkg
// Shared definitions for the calculator keypad path: button codes (also used by
// the calculator FSM), the encoder state type and the legal-code test.
package calc_pkg;

  localparam int NUM_KEYS = 10;

  // Digit keys: one-hot, bit i = digit i
  localparam logic [NUM_KEYS-1:0] BTN_0 = 10'b00_0000_0001;
  localparam logic [NUM_KEYS-1:0] BTN_1 = 10'b00_0000_0010;
  localparam logic [NUM_KEYS-1:0] BTN_2 = 10'b00_0000_0100;
  localparam logic [NUM_KEYS-1:0] BTN_3 = 10'b00_0000_1000;
  localparam logic [NUM_KEYS-1:0] BTN_4 = 10'b00_0001_0000;
  localparam logic [NUM_KEYS-1:0] BTN_5 = 10'b00_0010_0000;
  localparam logic [NUM_KEYS-1:0] BTN_6 = 10'b00_0100_0000;
  localparam logic [NUM_KEYS-1:0] BTN_7 = 10'b00_1000_0000;
  localparam logic [NUM_KEYS-1:0] BTN_8 = 10'b01_0000_0000;
  localparam logic [NUM_KEYS-1:0] BTN_9 = 10'b10_0000_0000;

  // Operator chords
  localparam logic [NUM_KEYS-1:0] BTN_ADD   = 10'b10_0000_0001;
  localparam logic [NUM_KEYS-1:0] BTN_SUB   = 10'b10_0000_0010;
  localparam logic [NUM_KEYS-1:0] BTN_MUL   = 10'b10_0000_0100;
  localparam logic [NUM_KEYS-1:0] BTN_DIV   = 10'b10_0000_1000;
  localparam logic [NUM_KEYS-1:0] BTN_EQUAL = 10'b11_0000_0000;
  localparam logic [NUM_KEYS-1:0] BTN_CLEAR = 10'b11_1000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } enc_state_t;

  // Exact-match test: any single key, or one of the six operator chords.
  function automatic logic is_legal_code(input logic [NUM_KEYS-1:0] code);
    logic legal;
    legal = $onehot(code);
    case (code)
      BTN_ADD, BTN_SUB, BTN_MUL, BTN_DIV, BTN_EQUAL, BTN_CLEAR: legal = 1'b1;
      default: ;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Module: key_debounce
// One key's conditioning: 2-FF synchroniser followed by a stability counter.
// The output follows the synchronised input only after it has disagreed with
// the current output for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      in  1  system clock
//   clear_n  in  1  async active-low reset (already release-synchronised)
//   raw      in  1  key level, active-high, async to clk
//   stable   out 1  debounced key level, active-high
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic clear_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // Stage p0/p1: metastability synchroniser, reset to the released level
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stability counter: the cycle it would reach DEBOUNCE_CYCLES the output
  // flips and the count restarts; any agreement in between clears it.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_p1 != stable) begin
      if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/calc_button_encoder.sv
// Module: calc_button_encoder
// Producer end of the calculator keypad: conditions 10 raw push-buttons,
// gathers simultaneous presses into one chord and emits one validated code
// per press-release cycle.
// Optional feature macro: CALC_CHORD_ERR_EN adds the chord_err output.
// Ports:
//   clk           in  1   system clock
//   clear_n       in  1   async active-low reset (released synchronously inside)
//   key_raw       in  10  raw key pins, async to clk
//   button        out 10  validated code, nonzero only with button_valid
//   button_valid  out 1   one-cycle strobe
//   key_state     out 10  debounced key levels, active-high
//   chord_err     out 1   (CALC_CHORD_ERR_EN only) pulses on an illegal chord
//   busy          out 1   FSM not in IDLE
module calc_button_encoder
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CHORD_CYCLES    = 2500000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] button,
  output logic                button_valid,
  output logic [NUM_KEYS-1:0] key_state,
`ifdef CALC_CHORD_ERR_EN
  output logic                chord_err,
`endif
  output logic                busy
);

  localparam int WW = $clog2(CHORD_CYCLES + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(CHORD_CYCLES - 1);

  logic                rst_sync_p0;
  logic                rst_sync_p1;
  logic                rst_n;
  logic [NUM_KEYS-1:0] key_norm;

  enc_state_t          state, state_nxt;
  logic [NUM_KEYS-1:0] chord, chord_nxt;
  logic [WW-1:0]       win_cnt, win_cnt_nxt;

  // Reset assertion propagates immediately; release is retimed to clk
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end
  assign rst_n = rst_sync_p1;

  // Everything downstream sees keys as active-high
  assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .clear_n(rst_n),
      .raw    (key_norm[i]),
      .stable (key_state[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      chord   <= '0;
      win_cnt <= '0;
    end else begin
      state   <= state_nxt;
      chord   <= chord_nxt;
      win_cnt <= win_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    chord_nxt    = chord;
    win_cnt_nxt  = win_cnt;
    button       = '0;
    button_valid = 1'b0;
`ifdef CALC_CHORD_ERR_EN
    chord_err    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (key_state != '0) begin
          chord_nxt   = key_state;
          win_cnt_nxt = '0;
          state_nxt   = COLLECT;
        end
      end
      COLLECT: begin
        // Keys only accumulate; the window is fixed from the first press
        chord_nxt   = chord | key_state;
        win_cnt_nxt = win_cnt + WW'(1);
        if (win_cnt == WIN_LAST || key_state == '0) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (is_legal_code(chord)) begin
          button       = chord;
          button_valid = 1'b1;
        end else begin
`ifdef CALC_CHORD_ERR_EN
          chord_err = 1'b1;
`endif
        end
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (key_state == '0) begin
          chord_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_calc_button_encoder.sv
module tb_calc_button_encoder;

  localparam int D = 4;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [9:0] key_raw;
  logic [9:0] button;
  logic       button_valid;
  logic [9:0] key_state;
  logic       busy;
`ifdef CALC_CHORD_ERR_EN
  logic       chord_err;
  int         n_err = 0;
`endif

  logic [9:0] exp_q[$];
  int n_vec    = 0;
  int n_fail   = 0;
  int n_strobe = 0;

  always #5 clk = ~clk;

  calc_button_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CHORD_CYCLES   (C),
    .KEY_ACTIVE_LOW (0)
  ) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .key_raw     (key_raw),
    .button      (button),
    .button_valid(button_valid),
    .key_state   (key_state),
`ifdef CALC_CHORD_ERR_EN
    .chord_err   (chord_err),
`endif
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a code
  always @(negedge clk) begin
    if (button_valid === 1'b1) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_strobe: got button=%b, expected no strobe", button);
      end else begin
        check("strobe_code", {22'd0, button}, {22'd0, exp_q.pop_front()});
      end
    end else if (button !== 10'd0) begin
      n_vec++;
      n_fail++;
      $display("FAIL button_idle: got %b without strobe, expected 0", button);
    end
`ifdef CALC_CHORD_ERR_EN
    if (chord_err === 1'b1) n_err++;
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && (busy !== 1'b0 || key_state !== 10'd0); i++) tick(1);
    check({name, "_busy_after_release"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic press(input logic [9:0] keys, input int hold);
    key_raw = keys;
    tick(hold);
    key_raw = '0;
  endtask

  initial begin
    int s0;
    int seen;
`ifdef CALC_CHORD_ERR_EN
    int e0;
`endif
    clear_n = 1'b0;
    key_raw = '0;
    tick(3);
    check("rst_button",       {22'd0, button},       32'd0);
    check("rst_button_valid", {31'd0, button_valid}, 32'd0);
    check("rst_key_state",    {22'd0, key_state},    32'd0);
    check("rst_busy",         {31'd0, busy},         32'd0);
    clear_n = 1'b1;
    tick(5);

    // 1. single digit
    s0 = n_strobe;
    exp_q.push_back(10'b00_0010_0000);
    press(10'b00_0010_0000, 40);
    wait_idle("t1");
    check("t1_strobes", n_strobe - s0, 1);
    tick(5);

    // 2. ADD chord, second key 6 cycles late but within the window
    s0 = n_strobe;
    exp_q.push_back(10'b10_0000_0001);
    key_raw = 10'b10_0000_0000;
    tick(6);
    key_raw = 10'b10_0000_0001;
    tick(60);
    key_raw = '0;
    wait_idle("t2");
    check("t2_strobes", n_strobe - s0, 1);
    tick(5);

    // 3. CLEAR chord, keys staggered by 3 cycles
    s0 = n_strobe;
    exp_q.push_back(10'b11_1000_0000);
    key_raw = 10'b10_0000_0000;
    tick(3);
    key_raw = 10'b11_0000_0000;
    tick(3);
    key_raw = 10'b11_1000_0000;
    tick(40);
    key_raw = '0;
    wait_idle("t3");
    check("t3_strobes", n_strobe - s0, 1);
    tick(5);

    // 4. bounce: high 2 / low 2, never long enough to debounce
    s0 = n_strobe;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      key_raw = ((i / 2) % 2 == 0) ? 10'b00_0000_1000 : 10'd0;
      tick(1);
      if (key_state !== 10'd0 || busy !== 1'b0) seen = 1;
    end
    key_raw = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (key_state !== 10'd0 || busy !== 1'b0) seen = 1;
    end
    check("t4_key_state_stays_0", seen, 0);
    check("t4_strobes", n_strobe - s0, 0);

    // 5. illegal chord dropped, then a normal digit
    s0 = n_strobe;
`ifdef CALC_CHORD_ERR_EN
    e0 = n_err;
`endif
    press(10'b00_0000_0110, 40);
    wait_idle("t5a");
    check("t5_illegal_strobes", n_strobe - s0, 0);
`ifdef CALC_CHORD_ERR_EN
    check("t5_chord_err_pulses", n_err - e0, 1);
`endif
    tick(5);
    s0 = n_strobe;
    exp_q.push_back(10'b00_0001_0000);
    press(10'b00_0001_0000, 40);
    wait_idle("t5b");
    check("t5_digit_strobes", n_strobe - s0, 1);
    tick(5);

    // 6. reset during COLLECT discards the chord
    s0 = n_strobe;
    key_raw = 10'b00_1000_0000;
    tick(10);
    check("t6_busy_in_collect", {31'd0, busy}, 32'd1);
    clear_n = 1'b0;
    key_raw = '0;
    #1;
    check("t6_rst_button",       {22'd0, button},       32'd0);
    check("t6_rst_button_valid", {31'd0, button_valid}, 32'd0);
    check("t6_rst_key_state",    {22'd0, key_state},    32'd0);
    check("t6_rst_busy",         {31'd0, busy},         32'd0);
    tick(2);
    clear_n = 1'b1;
    tick(5);
    check("t6_reset_strobes", n_strobe - s0, 0);
    exp_q.push_back(10'b00_1000_0000);
    press(10'b00_1000_0000, 40);
    wait_idle("t6");
    check("t6_strobes", n_strobe - s0, 1);
    tick(5);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
